// File: rtl/aes_iter_core_if.sv
// ---------------------------------------------------------------------------
// aes_iter_core_if
// Groups the key-load, block-in and block-out handshakes of aes_iter_core.
//   key_load    : single-cycle pulse, latches aes_key and starts expansion
//   aes_key     : 128-bit cipher key, byte 0 in [127:120]
//   key_ready   : all 11 round keys are valid
//   aes_start   : request to process aes_msg_in
//   aes_mode    : 0 = encrypt, 1 = decrypt (sampled with aes_start)
//   aes_msg_in  : 128-bit input block, byte 0 in [127:120]
//   aes_ready   : core accepts aes_start this cycle
//   aes_done    : aes_msg_out is valid and held
//   aes_ack     : consumer accepts the result
//   aes_msg_out : 128-bit result block
//   busy        : core is expanding a key or processing a block
// master = host side, slave = core side.
// ---------------------------------------------------------------------------
interface aes_iter_core_if;
  logic         key_load;
  logic [127:0] aes_key;
  logic         key_ready;
  logic         aes_start;
  logic         aes_mode;
  logic [127:0] aes_msg_in;
  logic         aes_ready;
  logic         aes_done;
  logic         aes_ack;
  logic [127:0] aes_msg_out;
  logic         busy;

  modport master (
    output key_load, aes_key, aes_start, aes_mode, aes_msg_in, aes_ack,
    input  key_ready, aes_ready, aes_done, aes_msg_out, busy
  );

  modport slave (
    input  key_load, aes_key, aes_start, aes_mode, aes_msg_in, aes_ack,
    output key_ready, aes_ready, aes_done, aes_msg_out, busy
  );
endinterface

// File: rtl/aes_iter_core.sv
// ---------------------------------------------------------------------------
// aes_iter_core
// Iterative AES-128 encrypt/decrypt engine with an internal key-expansion
// sequencer and an 11-entry round-key store. ROUNDS_PER_CYCLE rounds are
// unrolled per clock (1, 2, 5 or 10).
// Ports:
//   clk_i : single rising-edge clock
//   rst_i : synchronous, active-high reset
//   bus   : aes_iter_core_if.slave (key load, block in/out handshakes)
// ---------------------------------------------------------------------------
module aes_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit KEY_PRELOAD      = 1'b0
) (
  input logic            clk_i,
  input logic            rst_i,
  aes_iter_core_if.slave bus
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] RPC = 4'(ROUNDS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // ------------------------------------------------------------------------
  // GF(2^8) and AES round helpers
  // ------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    e = 8'hfe;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      r = e[i] ? gmul(r, p) : r;
      p = gmul(p, p);
    end
    return r;
  endfunction

  // S-box computed as inverse followed by the affine transform, so no table
  // has to be stored and both directions share the inverter.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return r;
  endfunction

  // Byte k sits at column k/4, row k%4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    t = last ? t : mix_columns(t);
    return t ^ rk;
  endfunction

  // Straight inverse cipher order: the key is added before InvMixColumns.
  function automatic logic [127:0] dec_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] t;
    t = inv_sub_bytes(inv_shift_rows(s)) ^ rk;
    return last ? t : inv_mix_columns(t);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One FIPS-197 word-group: next round key from the previous one.
  function automatic logic [127:0] key_expand(input logic [127:0] prev,
                                              input logic [7:0]   rc);
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {prev[23:0], prev[31:24]};
    t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = prev[127:96] ^ t;
    n1  = prev[95:64]  ^ n0;
    n2  = prev[63:32]  ^ n1;
    n3  = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic         key_ready_q, key_ready_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [127:0] msg_out_q, msg_out_d;
  logic [127:0] st_q, st_d;
  logic         mode_q, mode_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   kcnt_q, kcnt_d;
  logic         preload_q, preload_d;
  logic [127:0] rk_q [0:10];

  logic         rk_we_s;
  logic [3:0]   rk_widx_s;
  logic [127:0] rk_wdata_s;
  logic [3:0]   kprev_idx_s;
  logic         aes_ready_s;
  logic [127:0] run_st_s;
  logic [3:0]   rnd_idx_s;

  // Unrolled round chain: rounds rnd_q+1 .. rnd_q+ROUNDS_PER_CYCLE.
  always_comb begin
    run_st_s  = st_q;
    rnd_idx_s = 4'd0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd_idx_s = rnd_q + 4'(j) + 4'd1;
      rnd_idx_s = (rnd_idx_s > 4'd10) ? 4'd10 : rnd_idx_s;
      if (mode_q) begin
        run_st_s = dec_round(run_st_s, rk_q[4'd10 - rnd_idx_s], rnd_idx_s == 4'd10);
      end else begin
        run_st_s = enc_round(run_st_s, rk_q[rnd_idx_s], rnd_idx_s == 4'd10);
      end
    end
  end

  // Next-state and output decode for the IDLE/KEYEXP/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    key_ready_d = key_ready_q;
    done_d      = done_q;
    busy_d      = busy_q;
    msg_out_d   = msg_out_q;
    st_d        = st_q;
    mode_d      = mode_q;
    rnd_d       = rnd_q;
    kcnt_d      = kcnt_q;
    preload_d   = preload_q;
    rk_we_s     = 1'b0;
    rk_widx_s   = 4'd0;
    rk_wdata_s  = 128'h0;
    aes_ready_s = 1'b0;
    kprev_idx_s = (kcnt_q == 4'd0) ? 4'd0 : kcnt_q - 4'd1;

    case (state_q)
      ST_IDLE: begin
        aes_ready_s = key_ready_q & ~bus.key_load;
        // A key load (or the post-reset preload) wins over a block request.
        if (bus.key_load | preload_q) begin
          state_d     = ST_KEYEXP;
          preload_d   = 1'b0;
          key_ready_d = 1'b0;
          busy_d      = 1'b1;
          kcnt_d      = 4'd1;
          rk_we_s     = 1'b1;
          rk_widx_s   = 4'd0;
          rk_wdata_s  = bus.aes_key;
        end else if (bus.aes_start & aes_ready_s) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          mode_d  = bus.aes_mode;
          rnd_d   = 4'd0;
          st_d    = bus.aes_msg_in ^ (bus.aes_mode ? rk_q[10] : rk_q[0]);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_KEYEXP: begin
        rk_we_s    = 1'b1;
        rk_widx_s  = kcnt_q;
        rk_wdata_s = key_expand(rk_q[kprev_idx_s], rcon(kcnt_q));
        if (kcnt_q == 4'd10) begin
          state_d     = ST_IDLE;
          key_ready_d = 1'b1;
          busy_d      = 1'b0;
          kcnt_d      = 4'd0;
        end else begin
          kcnt_d = kcnt_q + 4'd1;
        end
      end

      ST_RUN: begin
        st_d = run_st_s;
        if (rnd_q + RPC >= 4'd10) begin
          rnd_d     = 4'd10;
          state_d   = ST_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          msg_out_d = run_st_s;
        end else begin
          rnd_d = rnd_q + RPC;
        end
      end

      ST_DONE: begin
        if (bus.aes_ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and data registers; reset aborts whatever state is active.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      key_ready_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      msg_out_q   <= 128'h0;
      st_q        <= 128'h0;
      mode_q      <= 1'b0;
      rnd_q       <= 4'd0;
      kcnt_q      <= 4'd0;
      preload_q   <= KEY_PRELOAD;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      msg_out_q   <= msg_out_d;
      st_q        <= st_d;
      mode_q      <= mode_d;
      rnd_q       <= rnd_d;
      kcnt_q      <= kcnt_d;
      preload_q   <= preload_d;
    end
  end

  // Round-key store, written one entry per cycle during expansion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 11; i++) rk_q[i] <= 128'h0;
    end else if (rk_we_s) begin
      rk_q[rk_widx_s] <= rk_wdata_s;
    end
  end

  assign bus.key_ready   = key_ready_q;
  assign bus.aes_ready   = aes_ready_s;
  assign bus.aes_done    = done_q;
  assign bus.aes_msg_out = msg_out_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Parametrised iterative AES-128 core that replaces the decrypt-only datapath with a unified encrypt/decrypt engine. It has an internal key-expansion sequencer and round-key store, and a configurable number of rounds unrolled per clock. Blocks enter through a START/READY handshake and leave through a DONE/ACK handshake, so the core can sit between the host-register interface and software without external sequencing.

Parameters:
ROUNDS_PER_CYCLE, 1, AES rounds computed per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration-time error.
KEY_PRELOAD, 0, if 1, the key schedule is expanded automatically on the first cycle after reset deasserts, using AES_KEY.

Ports:
CLK  in  1  single clock; all logic is rising-edge.
RESET  in  1  synchronous, active-high reset.
KEY_LOAD  in  1  single-cycle pulse that latches AES_KEY and starts key expansion.
AES_KEY  in  128  cipher key; byte 0 = [127:120].
KEY_READY  out  1  high once the 11 round keys are valid.
AES_START  in  1  request to process AES_MSG_IN.
AES_MODE  in  1  0 = encrypt, 1 = decrypt; sampled with AES_START.
AES_MSG_IN  in  128  input block; byte 0 = [127:120], column-major state.
AES_READY  out  1  core can accept AES_START this cycle.
AES_DONE  out  1  AES_MSG_OUT is valid and held.
AES_ACK  in  1  consumer accepts the result.
AES_MSG_OUT  out  128  result block.
BUSY  out  1  high in KEYEXP or RUN.

Behaviour:
- Reset (synchronous, active-high): state = IDLE. KEY_READY = 0, AES_READY = 0, AES_DONE = 0, BUSY = 0, AES_MSG_OUT = 0. The round-key store and round counter are cleared. Reset asserted in any state aborts that state in the same edge; no partial result is ever presented.
- States: IDLE, KEYEXP, RUN, DONE.
- IDLE:
  - KEY_LOAD = 1 -> KEYEXP. Takes priority over AES_START.
  - AES_READY = KEY_READY & ~KEY_LOAD. This is the only combinational input-to-output path.
  - AES_START & AES_READY -> accept the block:
    - latch the mode;
    - state register <= AES_MSG_IN ^ rk[0] (encrypt) or AES_MSG_IN ^ rk[10] (decrypt);
    - counter <= 0;
    - go to RUN.
- KEYEXP:
  - rk[0] = latched key; one FIPS-197 expansion word-group per cycle computes rk[1]..rk[10] using Rcon 01,02,04,08,10,20,40,80,1b,36.
  - Exactly 10 cycles, then KEY_READY <= 1 and return to IDLE.
  - KEY_READY = 0 throughout KEYEXP.
  - KEY_LOAD while in KEYEXP is ignored.
- RUN: each cycle applies ROUNDS_PER_CYCLE rounds. N = 10/ROUNDS_PER_CYCLE cycles, then DONE.
  - Encrypt round i (i = 1..10): SubBytes, ShiftRows, MixColumns (skipped when i = 10), AddRoundKey rk[i].
  - Decrypt round i (i = 1..10): InvShiftRows, InvSubBytes, AddRoundKey rk[10-i], InvMixColumns (skipped when i = 10).
  - S-box and inverse S-box are combinational inside this block; no registered ROM latency.
  - The counter is 4 bits and increments by ROUNDS_PER_CYCLE; it never wraps past 10.
- DONE:
  - AES_DONE = 1; AES_MSG_OUT holds the result stable until AES_ACK = 1.
  - On AES_ACK -> IDLE next cycle, with AES_DONE = 0 on that edge.
  - AES_MSG_OUT keeps its last value after ACK and updates only on the next DONE entry.
  - AES_START and KEY_LOAD are ignored in DONE. AES_READY = 0 in DONE.
- Latency: START accept edge to AES_DONE high is N+1 edges, i.e. 11 edges when R = 1 and 2 edges when R = 10. Throughput is one block per N+2 cycles with immediate ACK.
- AES_ACK outside DONE has no effect.
- KEY_LOAD outside IDLE is ignored. A new key never corrupts an in-flight block.
- KEY_PRELOAD = 1: after reset deasserts, the core enters KEYEXP automatically on the next edge.
- AES_MODE changes mid-RUN have no effect.

Test Plan:
- FIPS-197 C.1 vector (R = 1):
  - KEY_LOAD with key 000102030405060708090a0b0c0d0e0f -> KEY_READY rises exactly 10 cycles after the load edge.
  - Encrypt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a, with AES_DONE 11 edges after accept.
- Same key, decrypt 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
- Appendix B vector across parameters, for R = 1, 2, 5, 10 each:
  - key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32;
  - latencies 11, 6, 3 and 2 edges;
  - round trip via decrypt returns the plaintext.
- Handshake:
  - hold AES_ACK low 20 cycles -> AES_DONE and AES_MSG_OUT stable throughout;
  - AES_START pulsed in DONE is ignored;
  - ACK -> AES_READY high 1 cycle later.
- Collisions:
  - KEY_LOAD and AES_START in the same IDLE cycle -> AES_READY = 0, key expansion runs, block not accepted.
  - KEY_LOAD during RUN -> ignored, result matches the old key.
- Reset mid-RUN (cycle 4 of 10) -> next edge: all outputs 0, KEY_READY = 0; the next AES_START is refused until the key is reloaded.
